// File: rtl/s_crc_tag_gen.sv
// ---------------------------------------------------------------------------
// s_crc_tag_gen
//   Captures one 128-bit block from the S-box layer and computes a 32-bit
//   MSB-first CRC tag over its 16 bytes (byte 0 = in[127:120]).
//   The block and its tag are then presented downstream together on a
//   valid/ready handshake. Only one block is in flight at a time.
//
// Build option:
//   S_CRC_FAST_EN - when defined, fold 4 bytes per CALC cycle (4-cycle
//                   latency) instead of 1 byte per cycle (16-cycle latency).
//                   The tag values are identical in both builds.
//
// Ports:
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   in_valid   in   1    upstream block valid
//   in_ready   out  1    block accepted on in_valid && in_ready
//   in         in   128  block to tag
//   out_valid  out  1    out_data/out_crc valid
//   out_ready  in   1    downstream accepts on out_valid && out_ready
//   out_data   out  128  captured block, unmodified
//   out_crc    out  32   CRC tag of out_data
//   busy       out  1    high while a block is being tagged or presented
// ---------------------------------------------------------------------------
module s_crc_tag_gen #(
    parameter logic [31:0] CRC_POLY = 32'h04C11DB7,
    parameter logic [31:0] CRC_INIT = 32'hFFFFFFFF,
    parameter logic [31:0] XOR_OUT  = 32'hFFFFFFFF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [31:0]  out_crc,
    output logic         busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

`ifdef S_CRC_FAST_EN
    localparam logic [3:0] CNT_STEP = 4'd4;
    localparam logic [3:0] CNT_LAST = 4'd12;
`else
    localparam logic [3:0] CNT_STEP = 4'd1;
    localparam logic [3:0] CNT_LAST = 4'd15;
`endif

    // Fold one byte into the CRC, MSB first.
    function automatic logic [31:0] crc_fold8(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {b, 24'h000000};
        for (int i = 0; i < 8; i++) begin
            c = c[31] ? ({c[30:0], 1'b0} ^ CRC_POLY) : {c[30:0], 1'b0};
        end
        return c;
    endfunction

    // Fold four consecutive bytes (first byte in the top bits) at once;
    // for a non-reflected CRC this equals four sequential byte folds.
    function automatic logic [31:0] crc_fold32(input logic [31:0] crc, input logic [31:0] w);
        logic [31:0] c;
        c = crc ^ w;
        for (int i = 0; i < 32; i++) begin
            c = c[31] ? ({c[30:0], 1'b0} ^ CRC_POLY) : {c[30:0], 1'b0};
        end
        return c;
    endfunction

    state_t        state_q;
    logic [127:0]  block_q;
    logic [31:0]   crc_q;
    logic [3:0]    cnt_q;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          busy_q;
    logic [127:0]  out_data_q;
    logic [31:0]   out_crc_q;

    logic [127:0]  block_shift_s;
    logic [31:0]   crc_d;

    // Bring the byte(s) selected by the counter to the top of the block.
    assign block_shift_s = block_q << {cnt_q, 3'b000};

    // Next CRC value for the current CALC cycle.
    always_comb begin
        crc_d = crc_q;
`ifdef S_CRC_FAST_EN
        crc_d = crc_fold32(crc_q, block_shift_s[127:96]);
`else
        crc_d = crc_fold8(crc_q, block_shift_s[127:120]);
`endif
    end

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            block_q     <= 128'h0;
            crc_q       <= 32'h0;
            cnt_q       <= 4'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            out_data_q  <= 128'h0;
            out_crc_q   <= 32'h0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid && in_ready_q) begin
                        block_q    <= in;
                        crc_q      <= CRC_INIT;
                        cnt_q      <= 4'd0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_CALC;
                    end else begin
                        // First edge after reset release raises in_ready.
                        in_ready_q <= 1'b1;
                    end
                end
                ST_CALC: begin
                    crc_q <= crc_d;
                    cnt_q <= cnt_q + CNT_STEP;
                    if (cnt_q == CNT_LAST) begin
                        out_crc_q   <= crc_d ^ XOR_OUT;
                        out_data_q  <= block_q;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end else begin
                        state_q <= ST_CALC;
                    end
                end
                ST_DONE: begin
                    // out_data/out_crc keep their values after the handshake.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        state_q <= ST_DONE;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    cnt_q       <= 4'd0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_data  = out_data_q;
    assign out_crc   = out_crc_q;

endmodule

// File: tb/tb_s_crc_tag_gen.sv
// Bench for s_crc_tag_gen: one instance with default parameters driven by
// directed and random traffic and checked by a scoreboard, plus one instance
// with CRC_INIT=0 / XOR_OUT=FFFFFFFF for literal tag checks.
module tb_s_crc_tag_gen;

`ifdef S_CRC_FAST_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 16;
`endif
    localparam int RST_TICKS = (LAT == 16) ? 6 : 2;

    logic         clk;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] blk_in, out_data;
    logic [31:0]  out_crc;
    logic         p_in_valid, p_in_ready, p_out_valid, p_out_ready, p_busy;
    logic [127:0] p_in, p_out_data;
    logic [31:0]  p_out_crc;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int done_cnt = 0;
    bit seen_v = 1'b0;
    logic [127:0] hold_data;
    logic [31:0]  hold_crc;
    logic [159:0] exp_q[$];

    s_crc_tag_gen dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in(blk_in), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_crc(out_crc), .busy(busy)
    );

    s_crc_tag_gen #(
        .CRC_POLY(32'h04C11DB7), .CRC_INIT(32'h00000000), .XOR_OUT(32'hFFFFFFFF)
    ) dut_p (
        .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
        .in(p_in), .out_valid(p_out_valid), .out_ready(p_out_ready),
        .out_data(p_out_data), .out_crc(p_out_crc), .busy(p_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: polynomial long division of the 128 message bits, MSB first.
    function automatic logic [31:0] crc_model(input logic [31:0] init, input logic [31:0] xo,
                                              input logic [127:0] d);
        logic [31:0] c;
        logic fb;
        c = init;
        for (int i = 127; i >= 0; i--) begin
            fb = c[31] ^ d[i];
            c = {c[30:0], 1'b0};
            if (fb) c = c ^ 32'h04C11DB7;
        end
        return c ^ xo;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        total++;
        bad++;
        $display("FAIL %s: got=timeout want=event", nm);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard and per-cycle output checks on the default instance.
    always @(negedge clk) begin
        logic [159:0] e;
        if (!rst_n) begin
            exp_q.delete();
            seen_v = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                exp_q.push_back({blk_in, crc_model(32'hFFFFFFFF, 32'hFFFFFFFF, blk_in)});
                acc_cyc = cyc + 1;
            end
            if (out_valid) begin
                chk("no_overlap_in_ready", in_ready, 0);
                chk("busy_in_done", busy, 1);
                chk("tag_vs_model", out_crc, crc_model(32'hFFFFFFFF, 32'hFFFFFFFF, out_data));
                if (!seen_v) begin
                    seen_v = 1'b1;
                    chk("latency", cyc - acc_cyc, LAT);
                    hold_data = out_data;
                    hold_crc = out_crc;
                end else begin
                    chk("hold_data", out_data, hold_data);
                    chk("hold_crc", out_crc, hold_crc);
                end
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_block: got=extra want=none");
                    end else begin
                        e = exp_q.pop_front();
                        chk("order_data", out_data, e[159:32]);
                        chk("order_crc", out_crc, e[31:0]);
                    end
                    seen_v = 1'b0;
                    done_cnt++;
                end
            end
        end
    end

    task automatic send(input logic [127:0] blk, input bit rnd);
        int k = 0;
        logic a = 1'b0;
        in_valid = 1'b1;
        blk_in = blk;
        while (!a && k < 200) begin
            @(negedge clk);
            a = in_ready;
            tick();
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            k++;
        end
        in_valid = 1'b0;
        if (!a) fail_now("send_accept");
    endtask

    task automatic drain(input bit rnd);
        int k = 0;
        while ((exp_q.size() != 0 || out_valid) && k < 400) begin
            tick();
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            k++;
        end
        if (k >= 400) fail_now("drain");
    endtask

    task automatic run_p(input logic [127:0] blk, input logic [31:0] lit, input string nm);
        int k = 0;
        logic a = 1'b0;
        p_in_valid = 1'b1;
        p_in = blk;
        while (!a && k < 50) begin
            @(negedge clk);
            a = p_in_ready;
            tick();
            k++;
        end
        p_in_valid = 1'b0;
        if (!a) fail_now({nm, "_accept"});
        chk({nm, "_busy"}, p_busy, 1);
        k = 0;
        while (!p_out_valid && k < 100) begin
            tick();
            k++;
        end
        chk({nm, "_latency"}, k, LAT);
        chk({nm, "_crc_lit"}, p_out_crc, lit);
        chk({nm, "_crc_model"}, p_out_crc, crc_model(32'h0, 32'hFFFFFFFF, blk));
        chk({nm, "_data"}, p_out_data, blk);
        p_out_ready = 1'b1;
        tick();
        p_out_ready = 1'b0;
        chk({nm, "_valid_drop"}, p_out_valid, 0);
        chk({nm, "_ready_back"}, p_in_ready, 1);
        chk({nm, "_crc_kept"}, p_out_crc, lit);
    endtask

    initial begin
        int k;
        logic [127:0] blk_a, blk_b;
        rst_n = 1'b0;
        in_valid = 1'b0; blk_in = 128'h0; out_ready = 1'b0;
        p_in_valid = 1'b0; p_in = 128'h0; p_out_ready = 1'b0;

        // Model pinned against hand-computed tags.
        chk("model_poly", crc_model(32'h0, 32'h0, 128'h1), 32'h04C11DB7);
        chk("model_cksum", crc_model(32'h0, 32'hFFFFFFFF, 128'h00000000000000313233343536373839),
            32'h765E7680);

        #2;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_crc", out_crc, 0);
        #10 rst_n = 1'b1;
        #2;
        chk("pre_edge_in_ready", in_ready, 0);
        tick();
        chk("post_edge_in_ready", in_ready, 1);
        chk("post_edge_p_in_ready", p_in_ready, 1);

        // Literal tags with CRC_INIT=0, XOR_OUT=FFFFFFFF.
        run_p(128'h0, 32'hFFFFFFFF, "zero");
        run_p(128'h1, 32'hFB3EE248, "one");
        run_p(128'h00000000000000313233343536373839, 32'h765E7680, "cksum");

        // Backpressure in DONE with a competing block held upstream.
        blk_a = 128'h0123456789ABCDEFFEDCBA9876543210;
        blk_b = 128'hDEADBEEF00112233445566778899AABB;
        out_ready = 1'b0;
        send(blk_a, 1'b0);
        k = 0;
        while (!out_valid && k < 100) begin
            tick();
            k++;
        end
        if (!out_valid) fail_now("bp_wait_valid");
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            blk_in = blk_b;
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_valid_held", out_valid, 1);
            tick();
        end
        chk("bp_data_a", out_data, blk_a);
        out_ready = 1'b1;
        tick();
        chk("bp_hs_valid_low", out_valid, 0);
        chk("bp_hs_in_ready", in_ready, 1);
        send(blk_b, 1'b0);
        drain(1'b0);

        // Asynchronous reset in the middle of CALC.
        out_ready = 1'b0;
        send(128'hA5A5A5A55A5A5A5AC3C3C3C33C3C3C3C, 1'b0);
        repeat (RST_TICKS) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 0);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_crc", out_crc, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        #1;
        chk("rel_in_ready_pre", in_ready, 0);
        tick();
        chk("rel_in_ready_post", in_ready, 1);
        chk("rel_no_stale_valid", out_valid, 0);
        out_ready = 1'b1;
        send(128'h00000000FFFFFFFF00000000FFFFFFFF, 1'b0);
        drain(1'b0);

        // Back-to-back random blocks under random backpressure.
        for (int n = 0; n < 1000; n++) begin
            send({$urandom, $urandom, $urandom, $urandom}, 1'b1);
        end
        drain(1'b1);
        chk("blocks_done", done_cnt, 1003);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
